// File: rtl/mesi_bus_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mesi_bus_controller : MESI shared-bus arbiter, snoop collector, memory.   |
// | Optional round-robin arbitration with MESI_RR_ARB_EN (else fixed prio).   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module mesi_bus_controller #(
    parameter int NUM_CACHES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*NUM_CACHES-1:0] req_cmd,
    input  logic [8*NUM_CACHES-1:0] req_addr,
    input  logic [NUM_CACHES-1:0]   snoop_shared,
    input  logic [NUM_CACHES-1:0]   snoop_flush,
    input  logic [7:0]              flush_data,
    output logic [1:0]              bus_cmd,
    output logic [7:0]              bus_addr,
    output logic [NUM_CACHES-1:0]   bus_owner,
    output logic                    exclusive,
    output logic                    resp_valid,
    output logic [7:0]              resp_data,
    output logic                    busy
);

    localparam logic [1:0] c_BUS_RD   = 2'd1;
    localparam logic [1:0] c_BUS_UPGR = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNOOP  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NUM_CACHES-1:0] w_req_vec;
    logic                  w_req_any;
    logic [NUM_CACHES-1:0] w_win_oh;
    logic [1:0]            w_win_cmd;
    logic [7:0]            w_win_addr;
    int                    w_best_prio;
    logic [NUM_CACHES-1:0] r_win_oh;
    logic [1:0]            r_cmd;
    logic [7:0]            r_addr;
    logic                  r_shared_any;
    logic                  r_flush_any;
    logic [7:0]            r_flush_data;
    logic [7:0]            r_mem [256];

    for (genvar g = 0; g < NUM_CACHES; g++) begin : g_req
        assign w_req_vec[g] = |req_cmd[2*g +: 2];
    end
    assign w_req_any = |w_req_vec;

`ifdef MESI_RR_ARB_EN
    localparam int IDX_W = $clog2(NUM_CACHES);
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_next_ptr;
`endif

    // Smaller value = higher priority; distance from the pointer in round-robin mode.
    function automatic int prio(input int c);
`ifdef MESI_RR_ARB_EN
        return (c >= int'(r_ptr)) ? c - int'(r_ptr) : c + NUM_CACHES - int'(r_ptr);
`else
        return c;
`endif
    endfunction

    always_comb begin
        w_win_oh    = '0;
        w_win_cmd   = '0;
        w_win_addr  = '0;
        w_best_prio = NUM_CACHES;
`ifdef MESI_RR_ARB_EN
        w_next_ptr  = '0;
`endif
        for (int c = 0; c < NUM_CACHES; c++) begin
            if (w_req_vec[c] && (prio(c) < w_best_prio)) begin
                w_best_prio  = prio(c);
                w_win_oh     = '0;
                w_win_oh[c]  = 1'b1;
                w_win_cmd    = req_cmd[2*c +: 2];
                w_win_addr   = req_addr[8*c +: 8];
`ifdef MESI_RR_ARB_EN
                w_next_ptr   = (c == NUM_CACHES - 1) ? '0 : IDX_W'(c + 1);
`endif
            end
        end
    end

`ifdef MESI_RR_ARB_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_state == IDLE && w_req_any) begin
            r_ptr <= w_next_ptr;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_win_oh     <= '0;
            r_cmd        <= '0;
            r_addr       <= '0;
            r_shared_any <= 1'b0;
            r_flush_any  <= 1'b0;
            r_flush_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_req_any) begin
                r_win_oh <= w_win_oh;
                r_cmd    <= w_win_cmd;
                r_addr   <= w_win_addr;
            end
            if (r_state == SNOOP) begin
                // The requester's own snoop response never makes the line shared.
                r_shared_any <= |(snoop_shared & ~r_win_oh);
                r_flush_any  <= |snoop_flush;
                r_flush_data <= flush_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == SNOOP && (|snoop_flush)) begin
            r_mem[r_addr] <= flush_data;
        end
    end

    always_comb begin
        w_next_state = r_state;
        bus_cmd      = '0;
        bus_addr     = '0;
        bus_owner    = '0;
        exclusive    = 1'b0;
        resp_valid   = 1'b0;
        resp_data    = '0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_next_state = SNOOP;
                end
            end
            SNOOP: begin
                w_next_state = COMMIT;
                bus_cmd      = r_cmd;
                bus_addr     = r_addr;
                busy         = 1'b1;
            end
            COMMIT: begin
                w_next_state = IDLE;
                bus_cmd      = r_cmd;
                bus_addr     = r_addr;
                bus_owner    = r_win_oh;
                exclusive    = (r_cmd == c_BUS_RD) && !r_shared_any;
                resp_valid   = 1'b1;
                busy         = 1'b1;
                if (r_cmd == c_BUS_UPGR) begin
                    resp_data = '0;
                end else if (r_flush_any) begin
                    resp_data = r_flush_data;
                end else begin
                    resp_data = r_mem[r_addr];
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mesi_bus_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mesi_bus_controller : directed table, corner sequences, random model.  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_mesi_bus_controller;

    localparam int N  = 4;
    localparam int CW = 2 * N;

    logic            clk;
    logic            rst;
    logic [2*N-1:0]  req_cmd;
    logic [8*N-1:0]  req_addr;
    logic [N-1:0]    snoop_shared;
    logic [N-1:0]    snoop_flush;
    logic [7:0]      flush_data;
    logic [1:0]      bus_cmd;
    logic [7:0]      bus_addr;
    logic [N-1:0]    bus_owner;
    logic            exclusive;
    logic            resp_valid;
    logic [7:0]      resp_data;
    logic            busy;

    mesi_bus_controller #(.NUM_CACHES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_cmd      (req_cmd),
        .req_addr     (req_addr),
        .snoop_shared (snoop_shared),
        .snoop_flush  (snoop_flush),
        .flush_data   (flush_data),
        .bus_cmd      (bus_cmd),
        .bus_addr     (bus_addr),
        .bus_owner    (bus_owner),
        .exclusive    (exclusive),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*N-1:0] req_cmd;
        logic [8*N-1:0] req_addr;
        logic [2*N-1:0] req_mid;
        logic [N-1:0]   shared;
        logic [N-1:0]   flush;
        logic [7:0]     fdata;
        logic [N-1:0]   exp_owner;
        logic [1:0]     exp_cmd;
        logic [7:0]     exp_addr;
        logic           exp_excl;
        logic [7:0]     exp_data;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_mem [256];
`ifdef MESI_RR_ARB_EN
    int m_ptr;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus_cmd, bus_addr, bus_owner, exclusive, resp_valid, resp_data, busy});
    endfunction

    // Transaction-level reference: pick the winner by the arbitration rule, apply the snoop result.
    task automatic model_txn(inout vec_t v);
        int win;
        int c;
        logic sh;
        logic [1:0] cmd;
        logic [7:0] a;
        win = -1;
        for (int k = 0; k < N; k++) begin
`ifdef MESI_RR_ARB_EN
            c = (m_ptr + k) % N;
`else
            c = k;
`endif
            if (win < 0 && v.req_cmd[2*c +: 2] != 2'd0) win = c;
        end
        v.exp_owner = '0;
        v.exp_cmd   = '0;
        v.exp_addr  = '0;
        v.exp_excl  = 1'b0;
        v.exp_data  = '0;
        if (win < 0) return;
        cmd = v.req_cmd[2*win +: 2];
        a   = v.req_addr[8*win +: 8];
        v.exp_owner[win] = 1'b1;
        v.exp_cmd  = cmd;
        v.exp_addr = a;
        sh = |(v.shared & ~v.exp_owner);
        if (|v.flush) m_mem[a] = v.fdata;
        v.exp_excl = (cmd == 2'd1) && !sh;
        v.exp_data = (cmd == 2'd3) ? 8'h00 : m_mem[a];
`ifdef MESI_RR_ARB_EN
        m_ptr = (win + 1) % N;
`endif
    endtask

    task automatic do_txn(input string tag, input vec_t v);
        req_cmd  = v.req_cmd;
        req_addr = v.req_addr;
        @(posedge clk); #1;
        if (v.exp_owner == '0) begin
            check({tag, "_idle_stay"}, 64'({busy, resp_valid, bus_owner}), 64'd0);
            return;
        end
        check({tag, "_snoop"}, 64'({busy, bus_cmd, bus_addr, bus_owner, resp_valid}),
              64'({1'b1, v.exp_cmd, v.exp_addr, {N{1'b0}}, 1'b0}));
        req_cmd      = v.req_mid;
        snoop_shared = v.shared;
        snoop_flush  = v.flush;
        flush_data   = v.fdata;
        @(posedge clk); #1;
        check({tag, "_commit"},
              64'({busy, bus_cmd, bus_addr, bus_owner, exclusive, resp_valid, resp_data}),
              64'({1'b1, v.exp_cmd, v.exp_addr, v.exp_owner, v.exp_excl, 1'b1, v.exp_data}));
        snoop_shared = '0;
        snoop_flush  = '0;
        flush_data   = '0;
        @(posedge clk); #1;
        check({tag, "_done"}, 64'({busy, resp_valid, bus_owner, bus_cmd}), 64'd0);
    endtask

    function automatic vec_t mk(input int c, input logic [1:0] cmd, input logic [7:0] a,
                                input logic [N-1:0] sh, input logic [N-1:0] fl,
                                input logic [7:0] fd, input logic [N-1:0] eo,
                                input logic ex, input logic [7:0] ed);
        vec_t v;
        v = '0;
        v.req_cmd[2*c +: 2]  = cmd;
        v.req_addr[8*c +: 8] = a;
        v.req_mid   = v.req_cmd;
        v.shared    = sh;
        v.flush     = fl;
        v.fdata     = fd;
        v.exp_owner = eo;
        v.exp_cmd   = cmd;
        v.exp_addr  = a;
        v.exp_excl  = ex;
        v.exp_data  = ed;
        return v;
    endfunction

    vec_t tbl [8];

    initial begin
        vec_t v;
        vec_t mv;
        int   arb_win [4];

        rst = 1'b1;
        req_cmd = '0; req_addr = '0;
        snoop_shared = '0; snoop_flush = '0; flush_data = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
`ifdef MESI_RR_ARB_EN
        m_ptr = 0;
        arb_win = '{0, 1, 3, 0};
`else
        arb_win = '{0, 0, 0, 0};
`endif

        tbl[0] = mk(0, 2'd1, 8'h3C, 4'b0000, 4'b0000, 8'h00, 4'b0001, 1'b1, 8'h00);
        tbl[1] = mk(1, 2'd1, 8'h10, 4'b0100, 4'b0000, 8'h00, 4'b0010, 1'b0, 8'h00);
        tbl[2] = mk(1, 2'd1, 8'h11, 4'b0010, 4'b0000, 8'h00, 4'b0010, 1'b1, 8'h00);
        tbl[3] = mk(0, 2'd2, 8'h20, 4'b0000, 4'b1000, 8'hA5, 4'b0001, 1'b0, 8'hA5);
        tbl[4] = mk(0, 2'd1, 8'h20, 4'b0000, 4'b0000, 8'h00, 4'b0001, 1'b1, 8'hA5);
        tbl[5] = mk(2, 2'd3, 8'h44, 4'b0000, 4'b0010, 8'h77, 4'b0100, 1'b0, 8'h00);
        tbl[6] = mk(3, 2'd1, 8'h44, 4'b0000, 4'b0000, 8'h00, 4'b1000, 1'b1, 8'h77);
        tbl[7] = '0;

        repeat (2) @(posedge clk); #1;
        check("reset_outputs", all_outputs(), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", all_outputs(), 64'd0);

        // Reset while in SNOOP with a flush pending: transaction aborted, nothing written.
        req_cmd  = 8'b0000_0010;
        req_addr = 32'h0000_0050;
        @(posedge clk); #1;
        check("abort_in_snoop", 64'({busy, bus_cmd, bus_addr}), 64'({1'b1, 2'd2, 8'h50}));
        rst = 1'b1;
        snoop_flush = 4'b0010;
        flush_data  = 8'hEE;
        @(posedge clk); #1;
        check("abort_outputs_zero", all_outputs(), 64'd0);
        rst = 1'b0;
        req_cmd = '0; snoop_flush = '0; flush_data = '0;
        @(posedge clk); #1;
        check("abort_no_resp", 64'({resp_valid, busy}), 64'd0);

        // Caches 0, 1 and 3 request continuously.
        for (int g = 0; g < 4; g++) begin
            v = '0;
            v.req_cmd  = 8'b01_00_01_01;
            v.req_addr = 32'h03_00_02_01;
            v.req_mid  = v.req_cmd;
            v.exp_owner[arb_win[g]] = 1'b1;
            v.exp_cmd  = 2'd1;
            v.exp_addr = (arb_win[g] == 3) ? 8'h03 : 8'(arb_win[g] + 1);
            v.exp_excl = 1'b1;
            v.exp_data = 8'h00;
            mv = v;
            model_txn(mv);
            do_txn($sformatf("arb%0d", g), v);
        end
        req_cmd = '0;

        v = mk(0, 2'd1, 8'h50, 4'b0000, 4'b0000, 8'h00, 4'b0001, 1'b1, 8'h00);
        mv = v;
        model_txn(mv);
        do_txn("abort_mem_unchanged", v);

        for (int i = 0; i < 8; i++) begin
            mv = tbl[i];
            model_txn(mv);
            do_txn($sformatf("tbl%0d", i), tbl[i]);
        end

        for (int t = 0; t < 250; t++) begin
            v = '0;
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(1, 0) == 1) v.req_cmd[2*c +: 2] = 2'($urandom_range(3, 1));
                v.req_addr[8*c +: 8] = 8'($urandom_range(15, 0));
            end
            v.req_mid = CW'($urandom);
            v.shared  = N'($urandom);
            if ($urandom_range(2, 0) == 0) v.flush[$urandom_range(N-1, 0)] = 1'b1;
            v.fdata = 8'($urandom);
            model_txn(v);
            do_txn($sformatf("rnd%0d", t), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
